// File: rtl/audio_pkg.sv
// Shared definitions for the PCM mixing path feeding the pwm sample FIFO.
// Holds sample width, the silence code, the scheduler state encoding and the averaging helper.
package audio_pkg;

    localparam int unsigned PCM_W = 8;
    localparam logic [PCM_W-1:0] PCM_SILENCE = 8'h80;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGather = 2'd1,
        StPush   = 2'd2
    } mix_state_e;

    // Offset-binary mean of two samples; the 9-bit sum keeps the carry before truncation.
    function automatic logic [PCM_W-1:0] pcm_avg(input logic [PCM_W-1:0] a,
                                                 input logic [PCM_W-1:0] b);
        logic [PCM_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PCM_W:1];
    endfunction

endpackage

// File: rtl/pcm_chan_capture.sv
// Per-channel capture slot: one-sample holding register, got flag, ready generation and
// silence fill when the frame times out before this channel delivered.
module pcm_chan_capture
    import audio_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             en,
    input  logic             gather,
    input  logic             timeout,
    input  logic             valid,
    input  logic [PCM_W-1:0] data,
    output logic             ready,
    output logic             accept,
    output logic             missing,
    output logic             got_eff,
    output logic [PCM_W-1:0] sample_nxt
);

    logic             got_q, got_d;
    logic [PCM_W-1:0] sample_q, sample_d;

    assign ready   = gather & en & ~got_q;
    assign accept  = ready & valid;
    // Still owed a sample and not delivering it this cycle.
    assign missing = ready & ~valid;
    // A disabled channel never holds up the frame.
    assign got_eff = got_q | accept | ~en;

    always_comb begin
        got_d    = got_q;
        sample_d = sample_q;
        if (start) begin
            got_d    = 1'b0;
            sample_d = PCM_SILENCE;
        end else if (accept) begin
            got_d    = 1'b1;
            sample_d = data;
        end else if (timeout && missing) begin
            got_d    = 1'b1;
            sample_d = PCM_SILENCE;
        end
    end

    assign sample_nxt = sample_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            got_q    <= 1'b0;
            sample_q <= PCM_SILENCE;
        end else begin
            got_q    <= got_d;
            sample_q <= sample_d;
        end
    end

endmodule

// File: rtl/pcm_mix_sched.sv
// Frame scheduler sharing the pwm sample FIFO between two PCM producers: gathers one sample
// per enabled channel, fills late channels with silence, and pushes one mixed byte per frame.
module pcm_mix_sched
    import audio_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       ch_en,
    input  logic             ch0_valid,
    input  logic [PCM_W-1:0] ch0_data,
    output logic             ch0_ready,
    input  logic             ch1_valid,
    input  logic [PCM_W-1:0] ch1_data,
    output logic             ch1_ready,
    input  logic             fifo_full,
    output logic             fifo_we,
    output logic [PCM_W-1:0] fifo_data,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic             busy
);

    localparam int unsigned TCNT_W = 16;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    mix_state_e       state_q, state_d;
    logic [1:0]       en_q, en_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [PCM_W-1:0] mix_q, mix_d;
    logic [CNT_W-1:0] under_q, under_d;

    logic             start, gather, all_got, timeout;
    logic [1:0]       accept, missing, got_eff;
    logic [PCM_W-1:0] s0_nxt, s1_nxt;
    logic [1:0]       miss_n;
    logic [CNT_W:0]   under_sum;

    assign gather  = (state_q == StGather);
    assign start   = (state_q == StIdle) && (ch_en != 2'b00) && !fifo_full;
    assign all_got = &got_eff;
    // Accepts on the last GATHER cycle still count; only truly absent channels time out.
    assign timeout = gather && !all_got && (tcnt_q == TCNT_LAST);

    pcm_chan_capture u_ch0 (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .en         (en_q[0]),
        .gather     (gather),
        .timeout    (timeout),
        .valid      (ch0_valid),
        .data       (ch0_data),
        .ready      (ch0_ready),
        .accept     (accept[0]),
        .missing    (missing[0]),
        .got_eff    (got_eff[0]),
        .sample_nxt (s0_nxt)
    );

    pcm_chan_capture u_ch1 (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .en         (en_q[1]),
        .gather     (gather),
        .timeout    (timeout),
        .valid      (ch1_valid),
        .data       (ch1_data),
        .ready      (ch1_ready),
        .accept     (accept[1]),
        .missing    (missing[1]),
        .got_eff    (got_eff[1]),
        .sample_nxt (s1_nxt)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StGather;
            StGather: if (all_got || timeout) state_d = StPush;
            StPush:   if (!fifo_full) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        fifo_we = (state_q == StPush) && !fifo_full;
        busy    = (state_q != StIdle);
    end

    assign miss_n    = {1'b0, missing[0]} + {1'b0, missing[1]};
    assign under_sum = {1'b0, under_q} + {{(CNT_W - 1){1'b0}}, miss_n};

    always_comb begin
        en_d    = en_q;
        tcnt_d  = tcnt_q;
        mix_d   = mix_q;
        under_d = under_q;
        if (start) begin
            en_d   = ch_en;
            tcnt_d = '0;
        end
        if (gather) begin
            if (all_got || timeout) begin
                // Mix from next-state samples so the result is ready on PUSH entry.
                unique case (en_q)
                    2'b11:   mix_d = pcm_avg(s0_nxt, s1_nxt);
                    2'b01:   mix_d = s0_nxt;
                    2'b10:   mix_d = s1_nxt;
                    default: mix_d = PCM_SILENCE;
                endcase
            end else begin
                tcnt_d = tcnt_q + 16'd1;
            end
            if (timeout) begin
                under_d = under_sum[CNT_W] ? {CNT_W{1'b1}} : under_sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            en_q    <= 2'b00;
            tcnt_q  <= '0;
            mix_q   <= PCM_SILENCE;
            under_q <= '0;
        end else begin
            en_q    <= en_d;
            tcnt_q  <= tcnt_d;
            mix_q   <= mix_d;
            under_q <= under_d;
        end
    end

    assign fifo_data    = mix_q;
    assign underrun_cnt = under_q;

endmodule

// File: doc/pcm_mix_sched.md
Name: pcm_mix_sched

Overview:
- Frame scheduler that shares the single audio PWM sample FIFO between two 8-bit PCM producers, for example a CPU MMIO path and a DMA stream.
- Each frame it collects one sample from every enabled channel and averages them. It substitutes silence for any channel that misses a timeout, then pushes exactly one byte into the FIFO.
- It sits directly upstream of the pwm block: it drives the FIFO's write-enable and data inputs and consumes the FIFO's full flag.

Parameters:
- TIMEOUT, 1024, cycles allowed in GATHER before missing channels are filled with silence (legal range 2..65535).
- CNT_W, 16, width of the underrun counter.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- ch_en  in  2  channel enables [0]=ch0, [1]=ch1; sampled at frame start
- ch0_valid  in  1  ch0 sample available
- ch0_data  in  8  ch0 sample, unsigned offset-binary (0x80 = silence)
- ch0_ready  out  1  ch0 sample accepted this cycle
- ch1_valid  in  1  ch1 sample available
- ch1_data  in  8  ch1 sample, unsigned offset-binary
- ch1_ready  out  1  ch1 sample accepted this cycle
- fifo_full  in  1  pwm FIFO full
- fifo_we  out  1  push strobe to pwm FIFO
- fifo_data  out  8  mixed sample to pwm FIFO
- underrun_cnt  out  CNT_W  saturating count of silence substitutions
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (resetn sampled low at a clk edge, synchronous, active-low; clock clk):
  - state=IDLE; fifo_we=0, fifo_data=0x80, ch0_ready=ch1_ready=0, underrun_cnt=0, busy=0.
  - Capture flags, capture registers and timeout counter are cleared.
  - Reset mid-frame discards any captured samples; no push occurs.
- FSM states IDLE, GATHER, PUSH:
  - IDLE:
    - If ch_en!=0 and !fifo_full: latch en_q<=ch_en, clear got[1:0], tcnt<=0, go to GATHER.
    - Otherwise stay in IDLE.
  - GATHER:
    - chN_ready = en_q[N] & ~got[N] (combinational from registers).
    - A handshake occurs when chN_valid & chN_ready. It captures chN_data and sets got[N].
    - Data is held until consumed; ready is never asserted for a disabled channel.
    - all_got = (got | this cycle's accepts) covers en_q. If set, go to PUSH at the end of that cycle.
    - Else if tcnt==TIMEOUT-1: each missing enabled channel takes 0x80. underrun_cnt += number missing (1 or 2), saturating at all-ones. Go to PUSH.
    - Else tcnt<=tcnt+1.
  - PUSH:
    - fifo_data is registered and valid throughout PUSH.
    - fifo_we = (state==PUSH) & ~fifo_full.
    - If fifo_we is high, go to IDLE next cycle; exactly one push per frame.
    - While fifo_full is high, stay in PUSH with fifo_data stable and no duplicate push.
- Mix arithmetic:
  - Both enabled: fifo_data = (s0 + s1) >> 1, with a 9-bit sum, truncating.
  - One enabled: fifo_data = that channel's sample (or 0x80 on timeout).
- ch_en changes during GATHER or PUSH take effect next frame only.
- Latency, best case (both valid, FIFO not full): IDLE cycle 0 → GATHER cycle 1 (ready and accept) → PUSH cycle 2 (fifo_we=1) → IDLE cycle 3.
- Timeout boundary: accepts arriving on the tcnt==TIMEOUT-1 cycle are honoured; only channels still missing are filled.

Decomposition:
- Shared package audio_pkg holds:
  - state encoding (IDLE/GATHER/PUSH)
  - PCM_SILENCE = 8'h80
  - PCM_W = 8
- One natural sub-module, pcm_chan_capture, instantiated twice. It contains the got flag, the capture register, ready generation, and silence-fill on a timeout strobe.
- The FSM, mixer, timeout counter and underrun counter stay in the top level.

Test Plan:
- ch_en=11, ch0=0x40 and ch1=0xC0 both valid from start, fifo_full=0 → each ready high exactly 1 cycle; fifo_we pulse with fifo_data=0x80 on cycle 2; underrun_cnt=0.
- ch_en=01, ch0_data=0xFF valid, ch1_valid toggling → ch1_ready never high; push 0xFF; next frame starts at cycle 3.
- TIMEOUT=16, ch_en=11, ch0=0x20 valid, ch1 never valid → push fifo_data=(0x20+0x80)>>1=0x50 at GATHER-entry+16 cycles; underrun_cnt=1. Both silent → 0x80 and +2.
- Reach PUSH, hold fifo_full=1 for 10 cycles → fifo_we=0 and fifo_data constant throughout; single fifo_we pulse in the first cycle full=0; no double push.
- Reset asserted in GATHER after ch0 captured 0x33 → all outputs at reset values next cycle; after release a new frame re-requests ch0 and 0x33 is never pushed.
- ch_en=00 → busy=0, no ready or push. Preload underrun_cnt near saturation via forced timeouts → it holds at 0xFFFF and does not wrap.
